versatile_mem_ctrl_rx_align: RTL and testbench

Read-burst aligner directly downstream of the DDR2 PHY data path. It takes the registered 32-bit read word (two 16-bit DDR beats per clock) from the PHY's `rx_dat_o`. It uses the READ-command timing from the command sequencer to pick out exactly the valid burst words, tags them, and writes them into the Rx FIFO with a last-word marker. Overflow and command-collision errors are reported on sticky flags.

---
 rtl/versatile_mem_ctrl_pkg.sv | 16 +
 rtl/versatile_mem_ctrl_dly_line.sv | 27 ++
 rtl/versatile_mem_ctrl_rx_align.sv | 129 ++++++++++++
 tb/tb_versatile_mem_ctrl_rx_align.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/versatile_mem_ctrl_pkg.sv
// Shared definitions for the memory controller datapath blocks.
package versatile_mem_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rx_state_e;

  localparam int RD_LAT_DEF = 5;
  localparam int TAG_W_DEF  = 4;

  function automatic bit burst_words_ok(int n);
    return (n == 1) || (n == 2) || (n == 4) || (n == 8);
  endfunction

endpackage

// File: rtl/versatile_mem_ctrl_dly_line.sv
// DEPTH x WIDTH shift register; every stage is visible so callers can OR valid bits.
module versatile_mem_ctrl_dly_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [WIDTH-1:0]            d_i,
  output logic [WIDTH-1:0]            q_o,
  output logic [DEPTH-1:0][WIDTH-1:0] stages_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o      = sr_q[DEPTH-1];
  assign stages_o = sr_q;

endmodule

// File: rtl/versatile_mem_ctrl_rx_align.sv
// Read-burst aligner: uses delayed READ timing to pick burst words off the PHY
// and write them, tagged and last-marked, into the Rx FIFO.
module versatile_mem_ctrl_rx_align
  import versatile_mem_ctrl_pkg::*;
#(
  parameter int RD_LAT      = RD_LAT_DEF,
  parameter int BURST_WORDS = 4,
  parameter int TAG_W       = TAG_W_DEF
) (
  input  logic             clk_0,
  input  logic             rst,
  input  logic             rd_cmd_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  input  logic [31:0]      rx_dat_i,
  input  logic             fifo_full_i,
  input  logic             err_clr_i,
  output logic [31:0]      fifo_dat_o,
  output logic [TAG_W-1:0] fifo_tag_o,
  output logic             fifo_last_o,
  output logic             fifo_we_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int DW     = TAG_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_WORDS - 1);

  if (!burst_words_ok(BURST_WORDS)) begin : g_bad_bw
    $error("BURST_WORDS must be 1, 2, 4 or 8");
  end

  logic [RD_LAT-1:0][DW-1:0] dly_stages;
  logic [DW-1:0]             dly_out;
  logic [RD_LAT-1:0]         dly_vld;
  logic                      start;
  logic [TAG_W-1:0]          start_tag;

  versatile_mem_ctrl_dly_line #(.DEPTH(RD_LAT), .WIDTH(DW)) u_dly (
    .clk_i   (clk_0),
    .rst_i   (rst),
    .d_i     ({rd_cmd_i, rd_tag_i}),
    .q_o     (dly_out),
    .stages_o(dly_stages)
  );

  assign start     = dly_out[DW-1];
  assign start_tag = dly_out[TAG_W-1:0];

  always_comb begin
    dly_vld = '0;
    for (int i = 0; i < RD_LAT; i++) dly_vld[i] = dly_stages[i][DW-1];
  end

  rx_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d, idx;
  logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
  logic              active, err_set;
  logic              we_q, ovf_q, err_q, last_q;
  logic [31:0]       dat_q;
  logic [TAG_W-1:0]  tag_q;

  assign active = start | (state_q == BURST);
  assign idx    = start ? '0 : beat_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cur_tag_d = cur_tag_q;
    err_set   = 1'b0;
    if (start) begin
      // A start while still in BURST truncates the old burst.
      err_set = (state_q == BURST);
      if (BURST_WORDS == 1) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        state_d   = BURST;
        beat_d    = BEAT_W'(1);
        cur_tag_d = start_tag;
      end
    end else if (state_q == BURST) begin
      if (beat_q == LAST_BEAT) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      cur_tag_q <= '0;
      dat_q     <= '0;
      tag_q     <= '0;
      last_q    <= 1'b0;
      we_q      <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cur_tag_q <= cur_tag_d;
      we_q      <= active;
      if (active) begin
        dat_q  <= rx_dat_i;
        tag_q  <= start ? start_tag : cur_tag_q;
        last_q <= (idx == LAST_BEAT);
      end
      if (we_q && fifo_full_i) ovf_q <= 1'b1;
      else if (err_clr_i)      ovf_q <= 1'b0;
      if (err_set)             err_q <= 1'b1;
      else if (err_clr_i)      err_q <= 1'b0;
    end
  end

  assign fifo_dat_o  = dat_q;
  assign fifo_tag_o  = tag_q;
  assign fifo_last_o = last_q;
  assign fifo_we_o   = we_q & ~fifo_full_i;
  assign busy_o      = (|dly_vld) | (state_q == BURST) | we_q;
  assign ovf_o       = ovf_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_versatile_mem_ctrl_rx_align.sv
// Random READ traffic against a slot-schedule model of the burst aligner.
module tb_versatile_mem_ctrl_rx_align;
  localparam int RL = 5, BW = 4, TW = 4, N = 300, SZ = N + RL + BW + 8;

  logic clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  logic rst, rd_cmd, full, clr;
  logic [TW-1:0] rd_tag, f_tag;
  logic [31:0] rx_dat, f_dat;
  logic f_last, f_we, busy, ovf, err;

  logic cmd1;
  logic [TW-1:0] tag1, f_tag1;
  logic [31:0] rx1, f_dat1;
  logic f_last1, f_we1, busy1, ovf1, err1;

  versatile_mem_ctrl_rx_align #(.RD_LAT(RL), .BURST_WORDS(BW), .TAG_W(TW)) dut (
    .clk_0(clk_0), .rst(rst), .rd_cmd_i(rd_cmd), .rd_tag_i(rd_tag), .rx_dat_i(rx_dat),
    .fifo_full_i(full), .err_clr_i(clr), .fifo_dat_o(f_dat), .fifo_tag_o(f_tag),
    .fifo_last_o(f_last), .fifo_we_o(f_we), .busy_o(busy), .ovf_o(ovf), .err_o(err));

  versatile_mem_ctrl_rx_align #(.RD_LAT(1), .BURST_WORDS(1), .TAG_W(TW)) dut1 (
    .clk_0(clk_0), .rst(rst), .rd_cmd_i(cmd1), .rd_tag_i(tag1), .rx_dat_i(rx1),
    .fifo_full_i(1'b0), .err_clr_i(1'b0), .fifo_dat_o(f_dat1), .fifo_tag_o(f_tag1),
    .fifo_last_o(f_last1), .fifo_we_o(f_we1), .busy_o(busy1), .ovf_o(ovf1), .err_o(err1));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each READ claims BW word slots indexed by the edge that samples rx_dat_i.
  bit          sv[SZ];
  int          sk[SZ];
  logic [TW-1:0] stag[SZ];
  bit          errset[SZ];
  bit          cmdh[SZ], fullh[SZ], clrh[SZ];
  logic [31:0] rxh[SZ];

  task automatic run_phase(input int mode, input int cycles);
    logic [31:0] mdat;
    logic [TW-1:0] mtag;
    bit mlast, movf, merr, mbusy;
    int s;
    mdat = '0; mtag = '0; mlast = 0; movf = 0; merr = 0;
    for (int i = 0; i < SZ; i++) begin
      sv[i] = 0; sk[i] = 0; stag[i] = '0; errset[i] = 0;
      cmdh[i] = 0; fullh[i] = 0; clrh[i] = 0; rxh[i] = '0;
    end
    rst = 1'b1; rd_cmd = 0; full = 0; clr = 0; rx_dat = '0; rd_tag = '0;
    @(posedge clk_0); #1;
    chk("rst_we", {31'b0, f_we}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dat", f_dat, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (c < cycles - RL - BW - 3)
        rd_cmd = mode ? ($urandom_range(0, 2) == 0) : ((c % BW) == 0);
      else
        rd_cmd = 1'b0;
      rd_tag = TW'($urandom);
      rx_dat = $urandom;
      full   = ($urandom_range(0, 7) == 0);
      clr    = ($urandom_range(0, 15) == 0);
      cmdh[c] = rd_cmd; rxh[c] = rx_dat; fullh[c] = full; clrh[c] = clr;
      if (rd_cmd) begin
        s = c + 1 + RL;
        if (sv[s]) errset[s] = 1;
        for (int k = 0; k < BW; k++) begin
          sv[s+k] = 1; sk[s+k] = k; stag[s+k] = rd_tag;
        end
      end
      if (c > 0) begin
        if (sv[c-1] && fullh[c-1]) movf = 1;
        else if (clrh[c-1])        movf = 0;
        if (errset[c])             merr = 1;
        else if (clrh[c-1])        merr = 0;
        if (sv[c]) begin
          mdat = rxh[c-1]; mtag = stag[c]; mlast = (sk[c] == BW - 1);
        end
      end
      mbusy = sv[c];
      for (int j = c - RL; j < c; j++) if (j >= 0 && cmdh[j]) mbusy = 1;
      @(negedge clk_0);
      chk("we",   {31'b0, f_we},   {31'b0, sv[c] & ~fullh[c]});
      chk("dat",  f_dat,           mdat);
      chk("tag",  {28'b0, f_tag},  {28'b0, mtag});
      chk("last", {31'b0, f_last}, {31'b0, mlast});
      chk("busy", {31'b0, busy},   {31'b0, mbusy});
      chk("ovf",  {31'b0, ovf},    {31'b0, movf});
      chk("err",  {31'b0, err},    {31'b0, merr});
      @(posedge clk_0); #1;
    end
    rd_cmd = 0; full = 0; clr = 0;
  endtask

  initial begin
    rst = 1'b1; rd_cmd = 0; rd_tag = '0; rx_dat = '0; full = 0; clr = 0;
    cmd1 = 0; tag1 = '0; rx1 = '0;
    #12;
    run_phase(0, 80);
    run_phase(1, N);

    // Asynchronous reset in the middle of a burst.
    rd_cmd = 1; rd_tag = 4'd3;
    @(posedge clk_0); #1; rd_cmd = 0;
    repeat (RL + 2) @(posedge clk_0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we",   {31'b0, f_we},   32'd0);
    chk("mid_rst_last", {31'b0, f_last}, 32'd0);
    chk("mid_rst_tag",  {28'b0, f_tag},  32'd0);
    chk("mid_rst_dat",  f_dat,           32'd0);
    chk("mid_rst_busy", {31'b0, busy},   32'd0);
    @(posedge clk_0); #1; rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_0);
      chk("post_rst_we",   {31'b0, f_we}, 32'd0);
      chk("post_rst_busy", {31'b0, busy}, 32'd0);
    end

    // RD_LAT=1, BURST_WORDS=1: a command every cycle for three cycles.
    @(posedge clk_0); #1;
    for (int c = 0; c < 7; c++) begin
      cmd1 = (c < 3);
      tag1 = TW'(5 + c);
      rx1  = 32'hD000_0000 + 32'(c);
      @(negedge clk_0);
      if (c >= 2 && c <= 4) begin
        chk("deg_we",   {31'b0, f_we1},   32'd1);
        chk("deg_last", {31'b0, f_last1}, 32'd1);
        chk("deg_dat",  f_dat1,           32'hD000_0000 + 32'(c - 1));
        chk("deg_tag",  {28'b0, f_tag1},  32'(5 + c - 2));
      end else begin
        chk("deg_we_idle", {31'b0, f_we1}, 32'd0);
      end
      chk("deg_err", {31'b0, err1}, 32'd0);
      @(posedge clk_0); #1;
    end
    cmd1 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
